// File: rtl/shifter_pkg.sv
// Shared types for the sequential shifter and the ALU op decoder.
// Rotate support depends on the SEQ_SHIFTER_ROTATE_EN macro.
package shifter_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_SHL  = 3'd0,
    OP_SHR  = 3'd1,
    OP_SHRA = 3'd2,
    OP_ROL  = 3'd3,
    OP_ROR  = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // True when the code performs a real shift; every other code passes data through.
  function automatic logic op_shifts(input logic [OP_W-1:0] code);
    logic hit;
    hit = 1'b0;
    case (code)
      OP_SHL, OP_SHR, OP_SHRA: hit = 1'b1;
`ifdef SEQ_SHIFTER_ROTATE_EN
      OP_ROL, OP_ROR:          hit = 1'b1;
`endif
      default:                 hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves value by 0..STEP positions.
// Wrap logic exists only when SEQ_SHIFTER_ROTATE_EN is defined.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int SA_W  = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] value,
  input  op_e              op,
  input  logic [SA_W-1:0]  amount,
  output logic [WIDTH-1:0] shifted
);

  // NOTE: assign every always_comb output a default first so no path can infer a latch.
  always_comb begin
    shifted = value;
    case (op)
      OP_SHL:  shifted = value << amount;
      OP_SHR:  shifted = value >> amount;
      OP_SHRA: shifted = $signed(value) >>> amount;
`ifdef SEQ_SHIFTER_ROTATE_EN
      // A shift by WIDTH yields zero, so amount 0 leaves the value intact.
      OP_ROL:  shifted = (value << amount) | (value >> (WIDTH - int'(amount)));
      OP_ROR:  shifted = (value >> amount) | (value << (WIDTH - int'(amount)));
`endif
      default: shifted = value;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit with start/done handshake, STEP bits per clock.
// Define SEQ_SHIFTER_ROTATE_EN to enable ROL/ROR; otherwise they pass through.
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] shift_amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int SA_W = $clog2(STEP + 1);

  state_e           state, state_n;
  op_e              op_q, op_n;
  logic [WIDTH-1:0] work, work_n;
  logic [WIDTH-1:0] result_n;
  logic [WIDTH-1:0] shifted;
  logic [AMT_W-1:0] cnt, cnt_n;
  logic [AMT_W-1:0] step_cnt;
  logic [AMT_W-1:0] load_cnt;
  logic [SA_W-1:0]  step_amt;

  assign step_cnt = (int'(cnt) > STEP) ? AMT_W'(STEP) : cnt;
  assign step_amt = SA_W'(step_cnt);
  // Reserved (and, without rotate support, rotate) codes take the zero-count path.
  assign load_cnt = op_shifts(op) ? shift_amount : '0;

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .SA_W  (SA_W)
  ) u_shift_step (
    .value   (work),
    .op      (op_q),
    .amount  (step_amt),
    .shifted (shifted)
  );

  always_comb begin
    state_n  = state;
    op_n     = op_q;
    work_n   = work;
    cnt_n    = cnt;
    result_n = result;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          work_n = data_in;
          op_n   = op_e'(op);
          cnt_n  = load_cnt;
          if (load_cnt == '0) begin
            state_n  = ST_DONE;
            result_n = data_in;
          end else begin
            state_n = ST_RUN;
          end
        end else if (state == ST_DONE) begin
          state_n = ST_IDLE;
        end
      end
      ST_RUN: begin
        work_n = shifted;
        cnt_n  = cnt - step_cnt;
        if (cnt == step_cnt) begin
          state_n  = ST_DONE;
          result_n = shifted;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      op_q   <= OP_SHL;
      work   <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      state  <= state_n;
      op_q   <= op_n;
      work   <= work_n;
      cnt    <= cnt_n;
      result <= result_n;
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench: STEP=1 and STEP=4 instances share stimulus and are
// compared against an arithmetic reference model; honours SEQ_SHIFTER_ROTATE_EN.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] data_in;
  logic [4:0]  amt;
  logic        busy1, done1, busy4, done4;
  logic [31:0] res1, res4;

  int checks = 0;
  int errors = 0;
  int cur_op = 0;
  int cur_k  = 0;

`ifdef SEQ_SHIFTER_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(32), .STEP(1)) u_s1 (
    .clk(clk), .reset(reset), .start(start), .op(op), .data_in(data_in),
    .shift_amount(amt), .busy(busy1), .done(done1), .result(res1)
  );

  seq_shifter #(.WIDTH(32), .STEP(4)) u_s4 (
    .clk(clk), .reset(reset), .start(start), .op(op), .data_in(data_in),
    .shift_amount(amt), .busy(busy4), .done(done4), .result(res4)
  );

  function automatic logic [31:0] model(input logic [31:0] d, input int o, input int k);
    logic [31:0] r;
    case (o)
      0: r = d << k;
      1: r = d >> k;
      2: r = $signed(d) >>> k;
      3: r = (ROT && k != 0) ? ((d << k) | (d >> (32 - k))) : d;
      4: r = (ROT && k != 0) ? ((d >> k) | (d << (32 - k))) : d;
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic int model_lat(input int o, input int k, input int step);
    if (o > 4 || (!ROT && o >= 3) || k == 0) return 1;
    return (k + step - 1) / step + 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (op=%0d k=%0d): observed %h expected %h", tag, cur_op, cur_k, obs, exp);
    end
  endtask

  // Issue one operation, watch both instances until they signal done, then check.
  task automatic run_op(input logic [31:0] d, input int o, input int k);
    int lat1, lat4, busy_cnt;
    logic overlap;
    logic [31:0] r1, r4, exp_r;
    cur_op = o; cur_k = k;
    exp_r = model(d, o, k);
    @(negedge clk);
    data_in = d; op = 3'(o); amt = 5'(k); start = 1'b1;
    @(posedge clk);
    lat1 = 0; lat4 = 0; busy_cnt = 0; overlap = 1'b0; r1 = '0; r4 = '0;
    for (int c = 1; c <= 200 && (lat1 == 0 || lat4 == 0); c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy1 && lat1 == 0) busy_cnt++;
      if ((busy1 && done1) || (busy4 && done4)) overlap = 1'b1;
      if (done1 && lat1 == 0) begin lat1 = c; r1 = res1; end
      if (done4 && lat4 == 0) begin lat4 = c; r4 = res4; end
    end
    check("lat_step1", lat1, model_lat(o, k, 1));
    check("lat_step4", lat4, model_lat(o, k, 4));
    check("res_step1", r1, exp_r);
    check("res_step4", r4, exp_r);
    check("busy_cycles", busy_cnt, model_lat(o, k, 1) - 1);
    check("busy_done_overlap", {31'b0, overlap}, 32'd0);
    @(negedge clk);
    check("hold_step1", res1, exp_r);
    check("hold_step4", res4, exp_r);
  endtask

  // Count negedges (dropping start on the first) until instance 1 reports done.
  task automatic wait_done1(output int lat, output logic [31:0] r);
    lat = 0; r = '0;
    for (int c = 1; c <= 100 && lat == 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done1) begin lat = c; r = res1; end
    end
  endtask

  initial begin
    int lat;
    logic [31:0] r;
    reset = 1'b1; start = 1'b0; op = '0; data_in = '0; amt = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy1 | busy4}, 32'd0);
    check("rst_done", {31'b0, done1 | done4}, 32'd0);
    check("rst_result1", res1, 32'd0);
    check("rst_result4", res4, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_done", {31'b0, done1 | done4}, 32'd0);

    // Directed cases
    run_op(32'd5, 0, 3);
    run_op(32'hFFFF_FFF8, 2, 2);
    run_op(32'hFFFF_FFF8, 1, 2);
    run_op(32'h0000_0001, 4, 1);
    run_op(32'h8000_0001, 3, 4);
    run_op(32'd6, 0, 0);
    run_op(32'd1, 0, 9);
    run_op(32'h8000_0000, 2, 31);
    run_op(32'hDEAD_BEEF, 5, 7);
    run_op(32'h1234_5678, 7, 31);

    // start while busy is ignored
    cur_op = 0; cur_k = 3;
    @(negedge clk);
    data_in = 32'd5; op = 3'd0; amt = 5'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data_in = 32'h0000_FFFF; op = 3'd1; amt = 5'd1; start = 1'b1;
    wait_done1(lat, r);
    check("ignore_lat", lat, 32'd3);
    check("ignore_res1", r, 32'd40);
    check("ignore_res4", res4, 32'd40);
    repeat (2) @(negedge clk);

    // Back-to-back with start held across DONE
    @(negedge clk);
    data_in = 32'd5; op = 3'd0; amt = 5'd3; start = 1'b1;
    @(posedge clk);
    wait_done1(lat, r);
    check("b2b_first_lat", lat, 32'd4);
    check("b2b_first_res", r, 32'd40);
    data_in = 32'd7; op = 3'd0; amt = 5'd2; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("b2b_no_bubble", {31'b0, busy1}, 32'd1);
    check("b2b_done_low", {31'b0, done1}, 32'd0);
    wait_done1(lat, r);
    check("b2b_second_lat", lat, 32'd2);
    check("b2b_second_res", r, 32'd28);
    repeat (3) @(negedge clk);

    // Reset in the 2nd RUN cycle of SHL by 10
    cur_op = 0; cur_k = 10;
    @(negedge clk);
    data_in = 32'd1; op = 3'd0; amt = 5'd10; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("pre_rst_busy", {31'b0, busy1}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", {31'b0, busy1 | busy4}, 32'd0);
    check("mid_rst_done", {31'b0, done1 | done4}, 32'd0);
    check("mid_rst_res1", res1, 32'd0);
    check("mid_rst_res4", res4, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(32'h0000_00F0, 1, 4);

    // Randomized operations
    for (int i = 0; i < 30; i++) begin
      run_op($urandom, int'($urandom_range(0, 7)), int'($urandom_range(0, 31)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_shifter.md
# seq_shifter

Multi-cycle, parametrised shift/rotate unit for the datapath ALU, succeeding the single-cycle combinational left shifter. Accepts an operand, shift amount and operation code under a start/done handshake. Shifts by up to STEP bit positions per clock and presents a registered result. The ALU sequencer stalls on busy.

## Interface
- WIDTH, 32: operand and result width in bits (≥ 8, power of two).
- STEP, 1: maximum bit positions shifted per clock (power of two, 1..WIDTH).
- AMT_W, $clog2(WIDTH): number of shift_amount bits used.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy = 0.
- op  input  3  operation: 0 SHL, 1 SHR (logical), 2 SHRA (arithmetic), 3 ROL, 4 ROR; codes 5–7 reserved.
- data_in  input  WIDTH  operand, captured on an accepted start.
- shift_amount  input  AMT_W  shift count, captured on an accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- result  output  WIDTH  shifted value; held until the next accepted start.

## Operation
- The state machine has three states: IDLE, RUN, DONE.
- IDLE: on start = 1, capture data_in, op and shift_amount into working register and counter. Go to RUN if the count ≠ 0; go to DONE if the count = 0.
- RUN: each clock, shift the working register by min(STEP, remaining count) and decrement the counter by the same amount. When the counter reaches 0 after the update, go to DONE.
- DONE: done = 1 and result = working register for exactly this cycle.
  - start = 1 here is accepted, with the same capture and transition rules as IDLE. This allows back-to-back operations.
  - Otherwise go to IDLE.
- Fill rules:
  - SHL and SHR fill with 0.
  - SHRA fills with the captured MSB; repeated shifts converge to all-ones or all-zeros.
  - ROL and ROR wrap the bits that leave one end into the other end.
- Amount is unsigned and is effectively modulo WIDTH, because only AMT_W bits exist. A shift by WIDTH is therefore impossible.
- Reserved op codes: result = data_in, with a zero-count path (DONE next cycle).
- start while busy = 1 is ignored. It is not queued.
- result updates only on the DONE transition and otherwise holds its value.

## Timing
- Reset values: state IDLE, busy 0, done 0, result 0, counter 0.
- Latency: done is asserted ceil(k/STEP)+1 clocks after the accepting edge, for amount k. For k = 0 this is 1 clock.
- busy rises the cycle after acceptance and falls in the cycle done rises. busy and done are never high together.
- Throughput: one operation per ceil(k/STEP)+1 clocks, with no idle bubble when start is held across DONE.
- Reset asserted mid-operation immediately forces state IDLE, busy 0, done 0, result 0, and discards the operation. Reset has priority over start in the same cycle.

## Configuration
- SEQ_SHIFTER_ROTATE_EN:
  - Defined: ROL and ROR are implemented as specified.
  - Undefined: codes 3 and 4 are treated as reserved (pass-through, 1-clock done) and the wrap logic is not synthesised.

## Structure
- Package shifter_pkg holds:
  - the op enum typedef (SHL, SHR, SHRA, ROL, ROR), used by seq_shifter and the ALU decoder;
  - the state enum typedef;
  - the op-width constant.
- Sub-module shift_step: purely combinational; takes value, op and an amount 0..STEP, and returns a value shifted by that amount. It is instantiated once and the FSM/counter stay in seq_shifter.

## Test plan
- WIDTH=32, STEP=1: data_in 5, SHL, amount 3, start pulse -> busy for 3 clocks, done 4 clocks after accept, result 40.
- SHRA of 0xFFFFFFF8 by 2 -> 0xFFFFFFFE; SHR of same by 2 -> 0x3FFFFFFE.
- With SEQ_SHIFTER_ROTATE_EN:
  - ROR 0x00000001 by 1 -> 0x80000000.
  - ROL 0x80000001 by 4 -> 0x00000018.
- Without SEQ_SHIFTER_ROTATE_EN: ROL 0x80000001 by 4 -> 0x80000001, done 1 clock after accept.
- Amount 0 with data 6 -> done 1 clock after accept, busy never high, result 6.
- start re-pulsed with new operands while busy -> ignored, and the first result is unaltered.
- Back-to-back start held across DONE -> second operation accepted with no idle cycle.
- STEP=4: SHL 1 by 9 -> 3 RUN cycles, done 4 clocks after accept, result 0x00000200.
- Reset asserted in the 2nd RUN cycle of a SHL by 10 -> busy, done and result 0 immediately.
- After reset releases, a new start completes normally.
